// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: FSM state encoding, field
// widths and the wrap limits of the setpoint fields.
package alarm_pkg;

  localparam int HOUR_W   = 5;   // alarm_hour / hour width
  localparam int MIN_W    = 6;   // alarm_min / min / seg width
  localparam int CNT_W    = 9;   // ring / snooze seconds counter width
  localparam int HOUR_MAX = 23;  // highest legal hour
  localparam int MIN_MAX  = 59;  // highest legal minute

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_HOUR,
    S_SET_MIN,
    S_RINGING,
    S_SNOOZE
  } state_t;

endpackage

// File: rtl/wrap_counter.sv
// Up/down counter over the range 0..MAX that wraps in both directions.
// Coincident inc and dec cancel, so the value only ever holds legal values.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset, loads RST_VAL
//   inc    in  add one (MAX wraps to 0)
//   dec    in  subtract one (0 wraps to MAX)
//   value  out current count
module wrap_counter #(
  parameter int W       = 6,
  parameter int MAX     = 59,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] TOP  = W'(MAX);
  localparam logic [W-1:0] INIT = W'(RST_VAL);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= INIT;
    end else if (inc && !dec) begin
      value <= (value == TOP) ? '0 : value + 1'b1;
    end else if (dec && !inc) begin
      value <= (value == '0) ? TOP : value - 1'b1;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: alarm setpoint editing, arming, ringing with a
// 1 Hz buzzer, snooze and auto-dismiss.
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   tick_1hz                one-cycle pulse per second
//   hour, min, seg          current time of day
//   set_mode                level, requests setpoint editing
//   up_pulse, down_pulse    adjust the field being edited / snooze
//   sel_pulse               switch edit field / dismiss
//   arm_pulse               toggle armed
//   alarm_hour, alarm_min   setpoint
//   armed, editing, edit_field, ringing, buzzer   status outputs
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int RST_HOUR       = 7,
  parameter int RST_MIN        = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic [HOUR_W-1:0] hour,
  input  logic [MIN_W-1:0]  min,
  input  logic [MIN_W-1:0]  seg,
  input  logic              set_mode,
  input  logic              up_pulse,
  input  logic              down_pulse,
  input  logic              sel_pulse,
  input  logic              arm_pulse,
  output logic [HOUR_W-1:0] alarm_hour,
  output logic [MIN_W-1:0]  alarm_min,
  output logic              armed,
  output logic              editing,
  output logic              edit_field,
  output logic              ringing,
  output logic              buzzer
);

  // Counter values at which the current tick completes the period.
  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TIMEOUT_S - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_S - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             buzzer_next;
  logic             trigger;
  logic             disarm;

  wrap_counter #(.W(HOUR_W), .MAX(HOUR_MAX), .RST_VAL(RST_HOUR)) u_hour (
    .clk   (clk),
    .reset (reset),
    .inc   (up_pulse   && state == S_SET_HOUR),
    .dec   (down_pulse && state == S_SET_HOUR),
    .value (alarm_hour)
  );

  wrap_counter #(.W(MIN_W), .MAX(MIN_MAX), .RST_VAL(RST_MIN)) u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (up_pulse   && state == S_SET_MIN),
    .dec   (down_pulse && state == S_SET_MIN),
    .value (alarm_min)
  );

  assign trigger = armed && tick_1hz && (hour == alarm_hour) &&
                   (min == alarm_min) && (seg == '0);
  // Ringing and snooze are only reachable while armed, so an arm pulse there
  // always disarms.
  assign disarm  = arm_pulse && armed;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  // Leaving or entering a timed state clears the counter via the default.
  always_comb begin
    next_state  = state;
    cnt_next    = '0;
    buzzer_next = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (set_mode) begin
          next_state = S_SET_HOUR;
        end else if (trigger) begin
          next_state  = S_RINGING;
          buzzer_next = 1'b1;
        end
      end
      S_SET_HOUR: begin
        if (!set_mode)      next_state = S_IDLE;
        else if (sel_pulse) next_state = S_SET_MIN;
      end
      S_SET_MIN: begin
        if (!set_mode)      next_state = S_IDLE;
        else if (sel_pulse) next_state = S_SET_HOUR;
      end
      S_RINGING: begin
        if (disarm || sel_pulse) begin
          next_state = S_IDLE;
        end else if (up_pulse || down_pulse) begin
          next_state = S_SNOOZE;
        end else if (tick_1hz && cnt == RING_LAST) begin
          next_state = S_IDLE;
        end else begin
          cnt_next    = cnt + CNT_W'(tick_1hz);
          buzzer_next = buzzer ^ tick_1hz;
        end
      end
      S_SNOOZE: begin
        if (disarm || sel_pulse) begin
          next_state = S_IDLE;
        end else if (tick_1hz && cnt == SNOOZE_LAST) begin
          next_state  = S_RINGING;
          buzzer_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(tick_1hz);
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      buzzer <= 1'b0;
      armed  <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= cnt_next;
      buzzer <= buzzer_next;
      if (arm_pulse) armed <= ~armed;
    end
  end

  assign editing    = (state == S_SET_HOUR) || (state == S_SET_MIN);
  assign edit_field = (state == S_SET_MIN);
  assign ringing    = (state == S_RINGING);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed stimulus, a behavioural model
// compared every cycle, and literal expectations at key points.
module tb_alarm_ctrl;

  localparam int RING_T   = 60;
  localparam int SNOOZE_T = 300;
  localparam int M_IDLE = 0, M_SETH = 1, M_SETM = 2, M_RING = 3, M_SNZ = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0, set_mode = 1'b0;
  logic       up_pulse = 1'b0, down_pulse = 1'b0, sel_pulse = 1'b0, arm_pulse = 1'b0;
  logic [4:0] hour = 5'd7;
  logic [5:0] min = 6'd0, seg = 6'd5;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       armed, editing, edit_field, ringing, buzzer;

  int n_checks = 0, n_pass = 0;
  bit check_en = 1'b0;

  // Model: mode, setpoint as plain integers, seconds elapsed in the period.
  int m_mode = M_IDLE, m_hour = 7, m_min = 0, m_secs = 0;
  bit m_armed = 1'b0;

  always #5 clk = ~clk;

  alarm_ctrl #(.RING_TIMEOUT_S(RING_T), .SNOOZE_S(SNOOZE_T), .RST_HOUR(7), .RST_MIN(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .hour       (hour),
    .min        (min),
    .seg        (seg),
    .set_mode   (set_mode),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .sel_pulse  (sel_pulse),
    .arm_pulse  (arm_pulse),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .armed      (armed),
    .editing    (editing),
    .edit_field (edit_field),
    .ringing    (ringing),
    .buzzer     (buzzer)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic void model_step();
    int delta;
    int nxt;
    if (reset) begin
      m_mode = M_IDLE; m_hour = 7; m_min = 0; m_armed = 1'b0; m_secs = 0;
      return;
    end
    delta = int'(up_pulse) - int'(down_pulse);
    nxt = m_mode;
    case (m_mode)
      M_IDLE: begin
        if (set_mode) nxt = M_SETH;
        else if (m_armed && tick_1hz && int'(hour) == m_hour && int'(min) == m_min && seg == 0) begin
          nxt = M_RING; m_secs = 0;
        end
      end
      M_SETH, M_SETM: begin
        if (m_mode == M_SETH) m_hour = (m_hour + delta + 24) % 24;
        else                  m_min  = (m_min + delta + 60) % 60;
        if (!set_mode) nxt = M_IDLE;
        else if (sel_pulse) nxt = (m_mode == M_SETH) ? M_SETM : M_SETH;
      end
      M_RING: begin
        if (arm_pulse || sel_pulse) nxt = M_IDLE;
        else if (up_pulse || down_pulse) begin nxt = M_SNZ; m_secs = 0; end
        else if (tick_1hz) begin
          m_secs++;
          if (m_secs == RING_T) nxt = M_IDLE;
        end
      end
      default: begin
        if (arm_pulse || sel_pulse) nxt = M_IDLE;
        else if (tick_1hz) begin
          m_secs++;
          if (m_secs == SNOOZE_T) begin nxt = M_RING; m_secs = 0; end
        end
      end
    endcase
    if (arm_pulse) m_armed = !m_armed;
    m_mode = nxt;
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_alarm_hour", int'(alarm_hour), m_hour);
      check("cyc_alarm_min",  int'(alarm_min),  m_min);
      check("cyc_armed",      int'(armed),      int'(m_armed));
      check("cyc_editing",    int'(editing),    (m_mode == M_SETH || m_mode == M_SETM) ? 1 : 0);
      check("cyc_edit_field", int'(edit_field), (m_mode == M_SETM) ? 1 : 0);
      check("cyc_ringing",    int'(ringing),    (m_mode == M_RING) ? 1 : 0);
      // Buzzer is high on even elapsed seconds of a ring period.
      check("cyc_buzzer",     int'(buzzer),     (m_mode == M_RING && m_secs % 2 == 0) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    check_en = 1'b1;
    #1;
    tick_1hz = 1'b0; up_pulse = 1'b0; down_pulse = 1'b0; sel_pulse = 1'b0; arm_pulse = 1'b0;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    step();
  endtask

  // Alarm-time tick; seconds move off zero afterwards so it cannot refire.
  task automatic trigger_tick();
    seg = 6'd0;
    tick_1hz = 1'b1;
    step();
    seg = 6'd1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hour"},       int'(alarm_hour), 7);
    check({tag, "_min"},        int'(alarm_min),  0);
    check({tag, "_armed"},      int'(armed),      0);
    check({tag, "_ringing"},    int'(ringing),    0);
    check({tag, "_buzzer"},     int'(buzzer),     0);
    check({tag, "_editing"},    int'(editing),    0);
    check({tag, "_edit_field"}, int'(edit_field), 0);
  endtask

  initial begin
    reset = 1'b1; step(); step(); reset = 1'b0; step();
    check_reset_values("rst");

    // Edit minute down three times from 07:00.
    set_mode = 1'b1; step();
    check("edit_entry", int'(editing), 1);
    check("edit_field_hour", int'(edit_field), 0);
    sel_pulse = 1'b1; step();
    check("edit_field_min", int'(edit_field), 1);
    repeat (3) begin down_pulse = 1'b1; step(); end
    check("min_57", int'(alarm_min), 57);
    check("hour_7", int'(alarm_hour), 7);
    check("model_min_57", m_min, 57);
    set_mode = 1'b0; step();
    check("idle_after_edit", int'(editing), 0);
    up_pulse = 1'b1; step();
    check("idle_no_edit", int'(alarm_min), 57);

    // Hour wrap in both directions and coincident presses.
    set_mode = 1'b1; step();
    repeat (8) begin down_pulse = 1'b1; step(); end
    check("hour_23", int'(alarm_hour), 23);
    up_pulse = 1'b1; step();
    check("hour_wrap_0", int'(alarm_hour), 0);
    up_pulse = 1'b1; down_pulse = 1'b1; step();
    check("hour_coincident", int'(alarm_hour), 0);
    down_pulse = 1'b1; step();
    check("hour_wrap_23", int'(alarm_hour), 23);
    repeat (8) begin up_pulse = 1'b1; step(); end
    check("hour_back_7", int'(alarm_hour), 7);
    sel_pulse = 1'b1; step();
    up_pulse = 1'b1; down_pulse = 1'b1; step();
    check("min_coincident", int'(alarm_min), 57);
    repeat (2) begin up_pulse = 1'b1; step(); end
    check("min_59", int'(alarm_min), 59);
    up_pulse = 1'b1; step();
    check("min_wrap_0", int'(alarm_min), 0);
    check("min_edit_hour_kept", int'(alarm_hour), 7);
    set_mode = 1'b0; step();

    // Ring at 07:00:00, buzzer toggling, auto-dismiss after the timeout.
    arm_pulse = 1'b1; step();
    check("armed", int'(armed), 1);
    seg = 6'd0; step();
    check("no_ring_without_tick", int'(ringing), 0);
    trigger_tick();
    check("ring_start", int'(ringing), 1);
    check("buzz_start", int'(buzzer), 1);
    tick();
    check("buzz_toggle_0", int'(buzzer), 0);
    tick();
    check("buzz_toggle_1", int'(buzzer), 1);
    repeat (RING_T - 3) tick();
    check("ring_59", int'(ringing), 1);
    check("buzz_59", int'(buzzer), 0);
    tick();
    check("ring_timeout", int'(ringing), 0);
    check("ring_timeout_buzz", int'(buzzer), 0);

    // Snooze and re-ring, set_mode ignored, then dismiss.
    trigger_tick();
    check("ring_again", int'(ringing), 1);
    tick(); tick();
    up_pulse = 1'b1; step();
    check("snooze_ringing", int'(ringing), 0);
    check("snooze_buzzer", int'(buzzer), 0);
    set_mode = 1'b1; step();
    check("snooze_ignores_set", int'(editing), 0);
    set_mode = 1'b0;
    repeat (SNOOZE_T - 1) tick();
    check("snooze_299", int'(ringing), 0);
    tick();
    check("snooze_end_ring", int'(ringing), 1);
    check("snooze_end_buzz", int'(buzzer), 1);
    sel_pulse = 1'b1; step();
    check("dismiss", int'(ringing), 0);
    check("dismiss_armed", int'(armed), 1);

    // set_mode beats the trigger; disarm while ringing.
    set_mode = 1'b1;
    trigger_tick();
    check("set_wins_edit", int'(editing), 1);
    check("set_wins_ring", int'(ringing), 0);
    set_mode = 1'b0; step();
    trigger_tick();
    check("ring_before_disarm", int'(ringing), 1);
    arm_pulse = 1'b1; step();
    check("disarm_armed", int'(armed), 0);
    check("disarm_idle", int'(ringing), 0);

    // Move the setpoint to 07:01, ring, snooze, then reset mid-snooze.
    set_mode = 1'b1; step();
    sel_pulse = 1'b1; step();
    up_pulse = 1'b1; step();
    set_mode = 1'b0; step();
    check("min_01", int'(alarm_min), 1);
    arm_pulse = 1'b1; step();
    min = 6'd1;
    trigger_tick();
    check("ring_0701", int'(ringing), 1);
    down_pulse = 1'b1; step();
    tick(); tick(); tick();
    check("snoozing", int'(ringing), 0);
    reset = 1'b1; step();
    check_reset_values("snz_rst");
    reset = 1'b0; step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
